// File: rtl/microc_ctrl_if.sv
// microc_ctrl_if: control/status bundle between the microc datapath and its controller.
interface microc_ctrl_if;
    logic [5:0] opcode;
    logic       z;
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
    modport master (input opcode, z, output s_inc, s_inm, we, wez, alu_op);
    modport slave  (output opcode, z, input s_inc, s_inm, we, wez, alu_op);
endinterface

// File: rtl/microc_ctrl.sv
// microc_ctrl: run/halt control unit for the microc datapath; MICROC_CTRL_PERF_EN adds counters.
module microc_ctrl #(parameter int CNT_W = 16) (
    input  logic clk,
    input  logic reset,
    microc_ctrl_if.master bus,
    output logic halted,
    output logic illegal
`ifdef MICROC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_n;
    logic [3:0] op;
    logic run, taken;
    assign op = bus.opcode[5:2];
    assign run = state == RUN;
    assign taken = op == 4'b0010 || (op == 4'b0011 && bus.z) || (op == 4'b0100 && !bus.z);
    wire unused_ok = &{1'b0, bus.opcode[1:0]};
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= RUN;
        else state <= state_n;
    always_comb state_n = (run && op == 4'b0110) ? HALT : state;
    always_comb begin
        bus.we     = run && (op[3] || op[3:1] == 3'b000);
        bus.wez    = run && (op[3] || op == 4'b0001);
        bus.s_inm  = run && op[3:1] == 3'b000;
        bus.alu_op = !run ? 3'b000 : op[3] ? bus.opcode[4:2] : op == 4'b0001 ? 3'b010 : 3'b000;
        bus.s_inc  = !run ? 1'b0 : op == 4'b0010 ? 1'b0 : op == 4'b0011 ? ~bus.z :
                     op == 4'b0100 ? bus.z : op != 4'b0110;
        halted     = state == HALT;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) illegal <= 1'b0;
        else if (run && op == 4'b0111) illegal <= 1'b1;
`ifdef MICROC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else if (run) begin
            instr_cnt <= instr_cnt + 1'b1;
            if (taken) taken_cnt <= taken_cnt + 1'b1;
        end
`else
    localparam int unused_cnt_w = CNT_W;
    wire unused_taken = taken;
`endif
endmodule
